// File: rtl/mux_scan_pkg.sv
// -----------------------------------------------------------------------------
// mux_scan_pkg
// Shared definitions for the 8:1 multiplexer scan sequencer:
//   - FSM state encoding (IDLE, SCAN, FIN)
//   - channel count NCH, select width AW, settle counter width CNT_W
//   - first_enabled(): lowest enabled channel at or above a start index
// Compile-time option used by the importers: MUX_SCAN_MASK_EN
// -----------------------------------------------------------------------------
package mux_scan_pkg;

  localparam int NCH   = 8;
  localparam int AW    = 3;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FIN  = 2'd2
  } state_e;

  typedef struct packed {
    logic          found;
    logic [AW-1:0] ch;
  } chan_sel_t;

  // Lowest channel index >= from whose mask bit is set. 'from' is one bit
  // wider than a channel index so that "past channel 7" is representable.
  function automatic chan_sel_t first_enabled(input logic [NCH-1:0] mask,
                                              input logic [AW:0]    from);
    chan_sel_t r;
    r.found = 1'b0;
    r.ch    = {AW{1'b0}};
    // Walk downward so the last hit is the lowest qualifying channel.
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) begin
        r.found = 1'b1;
        r.ch    = i[AW-1:0];
      end else begin
        r.found = r.found;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/scan_settle_cnt.sv
// -----------------------------------------------------------------------------
// scan_settle_cnt
// Settle down-counter for the scan sequencer. Load has priority over
// decrement; the counter stops at zero.
// Ports:
//   clk_i       clock, rising edge
//   rst_ni      synchronous active-low reset (clears the count)
//   load_i      load load_val_i into the counter
//   en_i        decrement by one when non-zero
//   load_val_i  reload value (settle cycles minus one)
//   zero_o      high while the count is zero
// -----------------------------------------------------------------------------
module scan_settle_cnt
  import mux_scan_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load, else saturating decrement, else hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/mux_scan_seq.sv
// -----------------------------------------------------------------------------
// mux_scan_seq
// Scans the channels of an external 8:1 multiplexer: drives the select A,
// waits SETTLE cycles per channel, samples Y into the result bit for that
// channel, and publishes the full result on Q with a one-cycle DONE pulse.
// Parameter:
//   SETTLE  cycles each select is held before sampling (1..15)
// Ports:
//   CLK     clock, rising edge
//   RST_N   synchronous active-low reset
//   START   scan request (ignored unless idle)
//   A       channel select to the multiplexer
//   Y       selected data bit from the multiplexer
//   Q       last completed scan result, bit n = channel n
//   BUSY    high while scanning
//   DONE    one-cycle pulse when a scan completes
//   MASK    channel enables, latched at START (only with MUX_SCAN_MASK_EN)
// Compile-time option: MUX_SCAN_MASK_EN adds MASK and channel skipping.
// -----------------------------------------------------------------------------
module mux_scan_seq
  import mux_scan_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic           CLK,
  input  logic           RST_N,
`ifdef MUX_SCAN_MASK_EN
  input  logic [NCH-1:0] MASK,
`endif
  input  logic           START,
  output logic [AW-1:0]  A,
  input  logic           Y,
  output logic [NCH-1:0] Q,
  output logic           BUSY,
  output logic           DONE
);

  localparam logic [CNT_W-1:0] SETTLE_M1 = CNT_W'(SETTLE - 1);

  state_e         state_q, state_d;
  logic [AW-1:0]  a_q, a_d;
  logic [NCH-1:0] q_q, q_d;
  logic [NCH-1:0] res_q, res_d;
  logic [NCH-1:0] mask_q, mask_d;
  logic [NCH-1:0] mask_in_s;
  logic [NCH-1:0] res_smp_s;
  chan_sel_t      fe_start_s;
  chan_sel_t      fe_next_s;
  logic           cnt_load_s;
  logic           cnt_en_s;
  logic           cnt_zero_s;

`ifdef MUX_SCAN_MASK_EN
  assign mask_in_s = MASK;
`else
  assign mask_in_s = {NCH{1'b1}};
`endif

  // First channel of a new scan, and the next channel above the current one.
  assign fe_start_s = first_enabled(mask_in_s, {(AW+1){1'b0}});
  assign fe_next_s  = first_enabled(mask_q, {1'b0, a_q} + {{AW{1'b0}}, 1'b1});

  scan_settle_cnt u_settle (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .load_i     (cnt_load_s),
    .en_i       (cnt_en_s),
    .load_val_i (SETTLE_M1),
    .zero_o     (cnt_zero_s)
  );

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      a_q     <= {AW{1'b0}};
      q_q     <= {NCH{1'b0}};
      res_q   <= {NCH{1'b0}};
      mask_q  <= {NCH{1'b0}};
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      res_q   <= res_d;
      mask_q  <= mask_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    q_d        = q_q;
    res_d      = res_q;
    mask_d     = mask_q;
    cnt_load_s = 1'b0;
    cnt_en_s   = 1'b0;
    // Working result with the current channel's sample folded in.
    res_smp_s      = res_q;
    res_smp_s[a_q] = Y;
    case (state_q)
      IDLE: begin
        if (START) begin
          state_d    = SCAN;
          mask_d     = mask_in_s;
          res_d      = {NCH{1'b0}};
          cnt_load_s = 1'b1;
          // With nothing enabled A keeps its value; SCAN exits at once.
          if (fe_start_s.found) begin
            a_d = fe_start_s.ch;
          end else begin
            a_d = a_q;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (mask_q == {NCH{1'b0}}) begin
          state_d = FIN;
          q_d     = res_q;
        end else if (!cnt_zero_s) begin
          cnt_en_s = 1'b1;
        end else begin
          res_d = res_smp_s;
          if (fe_next_s.found) begin
            a_d        = fe_next_s.ch;
            cnt_load_s = 1'b1;
          end else begin
            state_d = FIN;
            q_d     = res_smp_s;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    BUSY = 1'b0;
    DONE = 1'b0;
    case (state_q)
      SCAN: begin
        BUSY = 1'b1;
        DONE = 1'b0;
      end
      FIN: begin
        BUSY = 1'b0;
        DONE = 1'b1;
      end
      default: begin
        BUSY = 1'b0;
        DONE = 1'b0;
      end
    endcase
  end

  assign A = a_q;
  assign Q = q_q;

endmodule

// File: tb/tb_mux_scan_seq.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_seq
// Self-checking bench for mux_scan_seq. Three instances with SETTLE = 2, 1
// and 3 share one clock; each has its own 8-bit data word D modelled behind
// the multiplexer (Y = D[A]). Stimulus tasks push the expected select trace
// and completion (cycle, Q) into per-instance queues; a monitor pops and
// compares whenever the DUT shows BUSY or DONE.
// Define MUX_SCAN_MASK_EN to build and exercise the masked variant.
// -----------------------------------------------------------------------------
module tb_mux_scan_seq;

`ifdef MUX_SCAN_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  typedef struct {
    int         cyc;
    logic [7:0] q;
  } exp_t;

  logic       clk;
  int         cyc;
  int         n_checks;
  int         n_errors;

  logic       rst_n_s  [3];
  logic       start_s  [3];
  logic [7:0] d_s      [3];
  logic [7:0] mask_s   [3];
  logic [2:0] a_s      [3];
  logic       y_s      [3];
  logic [7:0] q_s      [3];
  logic       busy_s   [3];
  logic       done_s   [3];
  bit         rst_edge [3];
  logic [7:0] last_q   [3];

  exp_t       exp_q [3][$];
  int         a_q   [3][$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mux_scan_seq #(.SETTLE((g == 0) ? 2 : ((g == 1) ? 1 : 3))) u_dut (
      .CLK   (clk),
      .RST_N (rst_n_s[g]),
`ifdef MUX_SCAN_MASK_EN
      .MASK  (mask_s[g]),
`endif
      .START (start_s[g]),
      .A     (a_s[g]),
      .Y     (y_s[g]),
      .Q     (q_s[g]),
      .BUSY  (busy_s[g]),
      .DONE  (done_s[g])
    );
    assign y_s[g] = d_s[g][a_s[g]];
  end

  function automatic int settle_of(input int g);
    case (g)
      0:       return 2;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  function automatic void check_eq(input string nm, input int g,
                                   input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d] @cyc %0d: got %0h expected %0h", nm, g, cyc, act, exp);
    end
  endfunction

  // Cycle count and which instances saw reset at this edge.
  always @(posedge clk) begin
    cyc++;
    for (int g = 0; g < 3; g++) rst_edge[g] = !rst_n_s[g];
  end

  // Monitor: compares DUT outputs against queued expectations.
  always @(negedge clk) begin
    exp_t e;
    int   ea;
    if (cyc > 0) begin
      for (int g = 0; g < 3; g++) begin
        if (rst_edge[g]) begin
          a_q[g].delete();
          last_q[g] = 8'h00;
          check_eq("rst_busy", g, 32'(busy_s[g]), 32'd0);
          check_eq("rst_done", g, 32'(done_s[g]), 32'd0);
          check_eq("rst_a",    g, 32'(a_s[g]),    32'd0);
          check_eq("rst_q",    g, 32'(q_s[g]),    32'd0);
        end else if (done_s[g] === 1'b1) begin
          if (exp_q[g].size() == 0) begin
            check_eq("done_unexp", g, 32'(done_s[g]), 32'd0);
          end else begin
            e = exp_q[g].pop_front();
            check_eq("done_q",   g, 32'(q_s[g]), 32'(e.q));
            check_eq("done_cyc", g, 32'(cyc),    32'(e.cyc));
            last_q[g] = e.q;
          end
          check_eq("done_busy",  g, 32'(busy_s[g]), 32'd0);
          check_eq("done_trace", g, 32'(a_q[g].size()), 32'd0);
        end else begin
          check_eq("q_hold", g, 32'(q_s[g]), 32'(last_q[g]));
          if (busy_s[g] === 1'b1) begin
            if (a_q[g].size() == 0) begin
              check_eq("busy_extra", g, 32'(busy_s[g]), 32'd0);
            end else begin
              ea = a_q[g].pop_front();
              if (ea >= 0) check_eq("a_sel", g, 32'(a_s[g]), 32'(ea));
            end
          end
        end
      end
    end
  end

  // One scan request on instance g, called at a negedge; returns at the
  // negedge after FIN so a following call is accepted back-to-back.
  task automatic scan(input int g, input logic [7:0] d, input logic [7:0] m,
                      input bit hold);
    int         s, n, acc, f;
    logic [7:0] em;
    exp_t       e;
    s  = settle_of(g);
    em = MASK_EN ? m : 8'hFF;
    d_s[g]     = d;
    mask_s[g]  = m;
    start_s[g] = 1'b1;
    acc = cyc + 1;
    n   = $countones(em);
    f   = (n == 0) ? acc + 1 : acc + n * s;
    if (n == 0) a_q[g].push_back(-1);
    for (int ch = 0; ch < 8; ch++)
      if (em[ch]) for (int r = 0; r < s; r++) a_q[g].push_back(ch);
    e.cyc = f;
    e.q   = d & em;
    exp_q[g].push_back(e);
    @(negedge clk);
    if (hold) begin
      while (cyc < f) @(negedge clk);
    end
    start_s[g] = 1'b0;
    mask_s[g]  = ~m;
    while (cyc < f + 1) @(negedge clk);
  endtask

  // Scan on instance g aborted by reset during its fifth busy cycle.
  task automatic scan_abort(input int g, input logic [7:0] d);
    int k;
    k = cyc;
    d_s[g]     = d;
    mask_s[g]  = 8'hFF;
    start_s[g] = 1'b1;
    for (int ch = 0; ch < 8; ch++)
      for (int r = 0; r < settle_of(g); r++) a_q[g].push_back(ch);
    @(negedge clk);
    start_s[g] = 1'b0;
    while (cyc < k + 5) @(negedge clk);
    rst_n_s[g] = 1'b0;
    @(negedge clk);
    rst_n_s[g] = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    bit         hold;
    int         g;
    logic [7:0] d;
    logic [7:0] m;
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    for (int i = 0; i < 3; i++) begin
      rst_n_s[i]  = 1'b0;
      start_s[i]  = 1'b0;
      d_s[i]      = 8'h00;
      mask_s[i]   = 8'hFF;
      last_q[i]   = 8'h00;
      rst_edge[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) rst_n_s[i] = 1'b1;
    @(negedge clk);

    // SETTLE=2 full scan, SETTLE=1 back-to-back, START held, reset abort.
    scan(0, 8'hA5, 8'hFF, 1'b0);
    repeat (2) @(negedge clk);
    scan(1, 8'h3C, 8'hFF, 1'b0);
    scan(1, 8'hFF, 8'hFF, 1'b0);
    repeat (2) @(negedge clk);
    scan(0, 8'h01, 8'hFF, 1'b1);
    repeat (2) @(negedge clk);
    scan_abort(0, 8'h5A);
`ifdef MUX_SCAN_MASK_EN
    scan(2, 8'hFF, 8'h81, 1'b0);
    repeat (2) @(negedge clk);
    scan(1, 8'hFF, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
`endif

    // Randomized scans across instances, data, masks and START shapes.
    for (int it = 0; it < 24; it++) begin
      g    = int'($urandom_range(0, 2));
      d    = 8'($urandom);
      m    = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      hold = 1'($urandom_range(0, 1));
      scan(g, d, m, hold);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_eq("drain_done",  i, 32'(exp_q[i].size()), 32'd0);
      check_eq("drain_trace", i, 32'(a_q[i].size()),   32'd0);
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mux_scan_seq.md
MUX_SCAN_SEQ -- requirements
Module: mux_scan_seq

Interface
REQ-001 SHALL have parameter SETTLE, default 2, meaning the number of clock cycles each select value is held before the selected data bit is sampled; the legal range is 1..15.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state updates occur on the rising edge.
REQ-003 SHALL have port RST_N, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port START, input, 1 bit: a scan request, sampled at each rising edge.
REQ-005 SHALL have port A, output, 3 bits: the channel select driven to the downstream 8:1 multiplexer.
REQ-006 SHALL have port Y, input, 1 bit: the selected data bit returned from the 8:1 multiplexer.
REQ-007 SHALL have port Q, output, 8 bits: the last completed scan result; bit n is the value of channel n.
REQ-008 SHALL have port BUSY, output, 1 bit: high while a scan is in progress.
REQ-009 SHALL have port DONE, output, 1 bit: a one-cycle pulse on scan completion.
REQ-010 SHALL have port MASK, input, 8 bits, present only when MUX_SCAN_MASK_EN is defined: the channel enables.

Function
REQ-011 SHALL implement the FSM states IDLE, SCAN and FIN; each is left only as listed below.
REQ-012 IDLE with START=1 at an edge SHALL give SCAN at that edge: A = first enabled channel, settle counter = SETTLE-1, BUSY=1.
REQ-013 In SCAN, each edge with counter != 0 SHALL decrement the counter and hold A.
REQ-014 In SCAN, an edge with counter == 0 SHALL store Y into internal result bit A, then:
- if a higher enabled channel exists: move A to the next enabled channel and reload the counter with SETTLE-1;
- otherwise: go to FIN.
REQ-015 On entry to FIN, Q SHALL receive the complete internal result, with unscanned bits = 0; DONE=1 and BUSY=0 for exactly that one cycle, then IDLE.
REQ-016 With all 8 channels enabled, START accepted at edge t SHALL produce DONE high in the cycle after edge t+8*SETTLE.
REQ-017 START SHALL be ignored in SCAN and FIN; there is no queuing and no restart.
REQ-018 Q SHALL hold the previous result throughout SCAN; it changes only on FIN entry.
REQ-019 A SHALL hold its last value in IDLE and FIN.
REQ-020 A SHALL step strictly upward; channel 7 is the last channel, and there is no wrap-around.

Reset
REQ-021 RST_N low at an edge SHALL force IDLE, A=0, Q=0, BUSY=0, DONE=0, counter=0 and internal result=0, regardless of START.
REQ-022 Reset during SCAN SHALL abort the scan; no DONE pulse is produced and Q is cleared.

Configuration
REQ-023 The macro MUX_SCAN_MASK_EN SHALL be the only compile-time option.
REQ-024 With MUX_SCAN_MASK_EN defined:
- the MASK port exists and is latched on START acceptance;
- channels with a 0 mask bit are skipped, spending zero cycles, and their Q bit = 0;
- if the latched MASK == 0, the next edge goes directly to FIN with Q = 0.
REQ-025 Without MUX_SCAN_MASK_EN: there is no MASK port, and all 8 channels are scanned in order 0..7.

Structure
REQ-026 The shared package mux_scan_pkg SHALL hold:
- the state encoding (IDLE, SCAN, FIN);
- the constants NCH=8 and AW=3;
- the counter width 4.
REQ-027 The settle down-counter SHALL be the single sub-module scan_settle_cnt, with inputs load, enable and a load value and a zero-flag output; all other logic SHALL be in mux_scan_seq.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- SETTLE=2, Y modelled as D[A] with D=8'hA5, START pulse -> A steps 0..7, each held 2 cycles; DONE in cycle 17 after the START edge; Q=8'hA5.
- SETTLE=1, back-to-back scans with D=8'h3C then D=8'hFF -> Q=8'h3C, then 8'hFF; Q holds 8'h3C during the second scan.
- START held high for the whole scan, D=8'h01 -> exactly one DONE per IDLE-to-SCAN transition; the mid-scan START is ignored.
- RST_N low at cycle 5 of a scan -> BUSY=0, Q=0, A=0 next cycle; no DONE.
- MUX_SCAN_MASK_EN, MASK=8'h81, SETTLE=3, D=8'hFF -> A visits only 0 and 7; DONE after 6 cycles; Q=8'h81.
- MUX_SCAN_MASK_EN, MASK=8'h00 -> FIN on the next edge; DONE pulse; Q=8'h00.
